// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity
// selectors and the 3-sample majority helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_e;

   localparam int PARITY_EVEN = 0;
   localparam int PARITY_ODD  = 1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchroniser and mid-bit majority voter. The first two samples are
// registered; the third is the live synchronised input, so bit_val is valid
// on the tick where cnt sits at the decision point.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OSR = 16,
   parameter int CW  = $clog2(OSR)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          baud_tick2,
   input  logic          rx,
   input  logic [CW-1:0] cnt,
   output logic          rx_s,
   output logic          bit_val
);

   localparam logic [CW-1:0] C_S0 = CW'(OSR/2 - 1);
   localparam logic [CW-1:0] C_S1 = CW'(OSR/2);

   logic [1:0] sync_d, sync_q;
   logic       s0_d, s0_q, s1_d, s1_q;

   // shift rx through the synchroniser, capture the two early samples
   always_comb begin
      sync_d = {sync_q[0], rx};
      s0_d   = s0_q;
      s1_d   = s1_q;
      if (baud_tick2 && cnt == C_S0) s0_d = sync_q[1];
      if (baud_tick2 && cnt == C_S1) s1_d = sync_q[1];
   end

   // sampler registers; synchroniser resets to the idle-high line level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         s0_q   <= 1'b0;
         s1_q   <= 1'b0;
      end else begin
         sync_q <= sync_d;
         s0_q   <= s0_d;
         s1_q   <= s1_d;
      end
   end

   assign rx_s    = sync_q[1];
   assign bit_val = maj3(s0_q, s1_q, sync_q[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, bit timing, shift register and the
// ready / error flag bookkeeping. Everything advances on baud_tick2 except
// the rdy_clr handling, which acts on any clock.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_EN   = 1,
   parameter int PARITY_TYPE = 0,
   parameter int STOP_BITS   = 1,
   parameter int OSR         = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick2,
   input  logic                 rx,
   input  logic                 rdy_clr,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rdy,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 break_det,
   output logic                 overrun_error,
   output logic                 busy
);

   localparam int CW = $clog2(OSR);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] C_MID = CW'(OSR/2 + 1);
   localparam logic [CW-1:0] C_END = CW'(OSR - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);
   localparam logic          ODD       = (PARITY_TYPE == PARITY_ODD);

   uart_state_e          state_d, state_q;
   logic [CW-1:0]        cnt_d, cnt_q;
   logic [BW-1:0]        bit_idx_d, bit_idx_q;
   logic                 stop_idx_d, stop_idx_q;
   logic [DATA_BITS-1:0] shift_d, shift_q, data_d, data_q;
   logic                 par_d, par_q, fe_acc_d, fe_acc_q;
   logic                 rdy_d, rdy_q, pe_d, pe_q, fe_d, fe_q;
   logic                 brk_d, brk_q, ovr_d, ovr_q, busy_d, busy_q;
   logic                 rx_s, bit_val, mid, last;
   logic                 done, f_pe, f_fe, f_brk;

   uart_rx_sampler #(.OSR(OSR), .CW(CW)) u_sampler (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_tick2 (baud_tick2),
      .rx         (rx),
      .cnt        (cnt_q),
      .rx_s       (rx_s),
      .bit_val    (bit_val)
   );

   assign mid  = (cnt_q == C_MID);
   assign last = (cnt_q == C_END);

   // frame FSM, bit timing and completion / flag next-state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      fe_acc_d   = fe_acc_q;
      data_d     = data_q;
      rdy_d      = rdy_q;
      pe_d       = pe_q;
      fe_d       = fe_q;
      brk_d      = brk_q;
      ovr_d      = ovr_q;
      done       = 1'b0;
      f_pe       = (PARITY_EN != 0) && ((^shift_q ^ par_q) != ODD);
      f_fe       = fe_acc_q | ~bit_val;
      f_brk      = (shift_q == '0) && !par_q && !bit_val;
      if (baud_tick2) begin
         cnt_d = cnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = START;
                  cnt_d   = CW'(1);
               end
            end
            START: begin
               if (mid && bit_val) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (last) begin
                  state_d   = DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end
            end
            DATA: begin
               if (mid) shift_d[bit_idx_q] = bit_val;
               if (last) begin
                  cnt_d = '0;
                  if (bit_idx_q == LAST_BIT) begin
                     state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                     stop_idx_d = 1'b0;
                     fe_acc_d   = 1'b0;
                  end else begin
                     bit_idx_d = bit_idx_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (mid) par_d = bit_val;
               if (last) begin
                  state_d    = STOP;
                  cnt_d      = '0;
                  stop_idx_d = 1'b0;
                  fe_acc_d   = 1'b0;
               end
            end
            STOP: begin
               // final stop completes at its decision point so the next
               // start edge can be caught without waiting out the bit
               if (mid && stop_idx_q == LAST_STOP) begin
                  done    = 1'b1;
                  state_d = f_brk ? BREAK : IDLE;
                  cnt_d   = '0;
               end else begin
                  if (mid && !bit_val) fe_acc_d = 1'b1;
                  if (last) begin
                     cnt_d      = '0;
                     stop_idx_d = 1'b1;
                  end
               end
            end
            BREAK: begin
               cnt_d = '0;
               if (rx_s) state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      if (rdy_clr) begin
         rdy_d = 1'b0;
         pe_d  = 1'b0;
         fe_d  = 1'b0;
         brk_d = 1'b0;
         ovr_d = 1'b0;
      end
      if (done) begin
         if (!rdy_q || rdy_clr) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            pe_d   = f_pe;
            fe_d   = f_fe;
            brk_d  = f_brk;
         end else begin
            ovr_d = 1'b1;
         end
      end
      busy_d = (state_d != IDLE);
   end

   // all receiver state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         fe_acc_q   <= 1'b0;
         data_q     <= '0;
         rdy_q      <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         brk_q      <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         fe_acc_q   <= fe_acc_d;
         data_q     <= data_d;
         rdy_q      <= rdy_d;
         pe_q       <= pe_d;
         fe_q       <= fe_d;
         brk_q      <= brk_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
      end
   end

   assign data_out      = data_q;
   assign rdy           = rdy_q;
   assign parity_error  = pe_q;
   assign framing_error = fe_q;
   assign break_det     = brk_q;
   assign overrun_error = ovr_q;
   assign busy          = busy_q;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the team's fixed 8-bit UART receiver, in the same serial-link path behind the baud generator's oversample tick. Adds:
- configurable data width, stop bits and oversampling ratio
- rx synchroniser and 3-sample majority vote
- framing, overrun and break detection
It presents a received word with a level-ready flag cleared by rdy_clr.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
PARITY_EN, 1, 1 = parity bit present, 0 = none
PARITY_TYPE, 0, 0 = even, 1 = odd
STOP_BITS, 1, 1 or 2 stop bits checked
OSR, 16, oversample ticks per bit; even, >= 8

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
baud_tick2  in  1  one-cycle enable at OSR x baud rate
rx  in  1  asynchronous serial input, idle high
rdy_clr  in  1  clears rdy, parity_error, framing_error, break_det, overrun_error
data_out  out  DATA_BITS  last accepted word
rdy  out  1  level: unread word in data_out
parity_error  out  1  parity mismatch on word in data_out
framing_error  out  1  a stop bit sampled low on word in data_out
break_det  out  1  break condition received
overrun_error  out  1  sticky: a frame completed while rdy=1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async):
  - all outputs 0; state IDLE; counters 0
  - shift register 0; synchroniser flops 1
- Input path:
  - rx passes through 2 flops on clk (rx_s).
  - Sampling uses rx_s only when baud_tick2 = 1; all state advances only on baud_tick2.
- Bit timing:
  - tick counter cnt runs 0..OSR-1 within each bit; width $clog2(OSR).
  - Samples taken at cnt = OSR/2-1, OSR/2, OSR/2+1.
  - Bit value is the majority of the 3 samples, decided at cnt = OSR/2+1.
- States:
  - IDLE -> START when rx_s = 0 on a tick. That tick is cnt = 0 of the start bit.
  - START:
    - majority 1 -> IDLE (glitch rejected; no flags change)
    - majority 0 -> continue; at cnt = OSR-1 -> DATA, bit_idx = 0
  - DATA: store majority into shift[bit_idx]. After bit DATA_BITS-1 completes -> PARITY if PARITY_EN, else STOP.
  - PARITY: capture parity bit p.
    - even: error when XOR(data, p) = 1
    - odd: error when XOR(data, p) = 0
  - STOP: check each of STOP_BITS bits; any low -> framing fault.
    - On the decision sample of the final stop bit, complete the frame.
    - Return to IDLE immediately, without waiting for the end of the bit, to allow resync.
  - BREAK: entered at completion when all data bits = 0, parity bit (if any) = 0 and the stop bit is low. Stays until rx_s = 1 on a tick -> IDLE.
- Completion, when rdy = 0, or rdy_clr = 1 in the same cycle:
  - data_out <= shift; rdy <= 1
  - parity_error and framing_error loaded with this frame's results
  - break_det <= 1 on break
- Completion when rdy = 1 and no rdy_clr:
  - data_out and flags unchanged; frame discarded; overrun_error <= 1
- Simultaneous rdy_clr and completion: completion wins, and overrun is not set. rdy_clr clears overrun_error the same cycle unless a new overrun occurs in that cycle; the new overrun wins.
- rdy_clr with no completion: clears rdy and all four error flags next edge; data_out holds.
- Latency: rdy rises 1 clk after the final-stop decision tick. This is 2 clk plus the synchroniser delay after the rx transition that lies ~OSR/2+1 ticks earlier.
- Reset mid-frame aborts immediately: no rdy, flags 0.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package uart_pkg:
  - state encoding localparams IDLE, START, DATA, PARITY, STOP, BREAK (3-bit)
  - PARITY_EVEN = 0, PARITY_ODD = 1
  - shared with the transmitter
- Sub-module uart_rx_sampler:
  - 2-flop synchroniser plus 3-sample majority register
  - inputs: clk, rst_n, baud_tick2, rx, cnt
  - outputs: rx_s, bit_val
- Top: FSM, counters, shift register, flags.

Test Plan:
- Defaults (8E1, OSR 16); send 0xA5 with p = 0, stop 1 -> data_out = 0xA5, rdy = 1, all error flags 0, busy low after.
- Same frame with p = 1 -> rdy = 1, data_out = 0xA5, parity_error = 1; pulse rdy_clr -> rdy = 0, parity_error = 0.
- 0x3C with correct parity, stop bit 0 -> framing_error = 1, break_det = 0, rdy = 1. Then hold rx low 12 bit-times -> no further rdy; rx high -> next 0x5A received cleanly.
- rx low for 2 ticks then high -> state returns to IDLE, rdy stays 0. A single-tick low glitch at mid-bit of a data 1 is still read as 1.
- Frames 0x11 then 0x22 without rdy_clr -> data_out = 0x11, overrun_error = 1; rdy_clr -> overrun_error = 0.
- DATA_BITS = 7, PARITY_EN = 0, STOP_BITS = 2, OSR = 8; send 0x55 with second stop low -> framing_error = 1. Assert rst_n low mid-data -> all outputs 0 asynchronously.
